// File: rtl/serial_adder_if.sv
// Handshake bundle for serial_adder: operand input channel, result output channel and status.
// Define SERIAL_ADDER_COUT_EN to carry the final carry-out alongside the sum.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             busy;
`ifdef SERIAL_ADDER_COUT_EN
   logic             cout;
`endif

   modport slave (
      input  in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADDER_COUT_EN
      output cout,
`endif
      output in_ready, out_valid, sum, busy
   );

   modport master (
      output in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADDER_COUT_EN
      input  cout,
`endif
      input  in_ready, out_valid, sum, busy
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder, one bit per clock LSB first; result valid WIDTH edges after accept.
// One operation in flight: in_ready only in IDLE, result held in DONE until out_ready; cout via SERIAL_ADDER_COUT_EN.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_adder_if.slave bus
);
   localparam int            CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] sum_shift;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic             ha1_s;
   logic             ha1_c;
   logic             ha2_s;
   logic             ha2_c;
   logic             fa_c;
   logic             accept;

   // Full add of the current bit built from two half-add stages.
   always_comb begin
      ha1_s = a_q[0] ^ b_q[0];
      ha1_c = a_q[0] & b_q[0];
      ha2_s = ha1_s ^ carry_q;
      ha2_c = ha1_s & carry_q;
      fa_c  = ha1_c | ha2_c;
   end

   generate
      if (WIDTH == 1) begin : g_w1
         assign sum_shift = ha2_s;
      end else begin : g_wn
         assign sum_shift = {ha2_s, sum_q[WIDTH-1:1]};
      end
   endgenerate

   always_comb begin
      state_d      = state_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      accept        = 1'b0;
      case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               accept  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            bus.busy = 1'b1;
            if (cnt_q == LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else if (accept) begin
         a_q     <= bus.a;
         b_q     <= bus.b;
         carry_q <= bus.cin;
         cnt_q   <= '0;
      end else if (state_q == SHIFT) begin
         a_q     <= a_q >> 1;
         b_q     <= b_q >> 1;
         sum_q   <= sum_shift;
         carry_q <= fa_c;
         cnt_q   <= cnt_q + CW'(1);
      end
   end

   assign bus.sum = sum_q;

   // carry_q is frozen outside SHIFT, so it holds the final carry through DONE.
`ifdef SERIAL_ADDER_COUT_EN
   assign bus.cout = carry_q;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: table of 8-bit vectors plus backpressure, reset, overlap and WIDTH=1 sequences.
module tb_serial_adder;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   serial_adder_if #(.WIDTH(8)) if8 ();
   serial_adder_if #(.WIDTH(1)) if1 ();

   serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
   serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] sum;
      logic       cout;
   } vec_t;

   vec_t vecs[8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Handshake one operand set on dut8 and wait for out_valid; leaves the bench at the first DONE negedge.
   task automatic start8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                         input logic ordy, input string nm);
      int cyc;
      check({nm, " in_ready before"}, 32'(if8.in_ready), 32'd1);
      if8.in_valid  = 1'b1;
      if8.a         = av;
      if8.b         = bv;
      if8.cin       = ci;
      if8.out_ready = ordy;
      @(negedge clk);
      if8.in_valid = 1'b0;
      check({nm, " busy"}, 32'(if8.busy), 32'd1);
      cyc = 0;
      while (!if8.out_valid && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check({nm, " latency"}, 32'(cyc), 32'd8);
   endtask

   task automatic finish8(input logic [7:0] es, input logic ec, input string nm);
      check({nm, " sum"}, 32'(if8.sum), 32'(es));
`ifdef SERIAL_ADDER_COUT_EN
      check({nm, " cout"}, 32'(if8.cout), 32'(ec));
`else
      if (ec === 1'bx) $display("unused carry");
`endif
      @(negedge clk);
      check({nm, " in_ready after"}, 32'(if8.in_ready), 32'd1);
      check({nm, " out_valid after"}, 32'(if8.out_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      total = 0;
      bad   = 0;
      vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
      vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
      vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
      vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
      vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

      rst_n         = 1'b0;
      if8.in_valid  = 1'b0;
      if8.a         = '0;
      if8.b         = '0;
      if8.cin       = 1'b0;
      if8.out_ready = 1'b1;
      if1.in_valid  = 1'b0;
      if1.a         = '0;
      if1.b         = '0;
      if1.cin       = 1'b0;
      if1.out_ready = 1'b1;

      repeat (2) @(negedge clk);
      check("reset in_ready", 32'(if8.in_ready), 32'd1);
      check("reset out_valid", 32'(if8.out_valid), 32'd0);
      check("reset busy", 32'(if8.busy), 32'd0);
      check("reset sum", 32'(if8.sum), 32'd0);
`ifdef SERIAL_ADDER_COUT_EN
      check("reset cout", 32'(if8.cout), 32'd0);
`endif

      // First vector is presented as reset releases, so it is taken on the first rising edge.
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         start8(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1, $sformatf("vec%0d", i));
         finish8(vecs[i].sum, vecs[i].cout, $sformatf("vec%0d", i));
      end

      // Backpressure: result held for 5 cycles with out_ready low.
      start8(8'h5A, 8'h33, 1'b0, 1'b0, "hold");
      for (int i = 0; i < 5; i++) begin
         check("hold out_valid", 32'(if8.out_valid), 32'd1);
         check("hold sum", 32'(if8.sum), 32'h8D);
         check("hold in_ready", 32'(if8.in_ready), 32'd0);
`ifdef SERIAL_ADDER_COUT_EN
         check("hold cout", 32'(if8.cout), 32'd0);
`endif
         @(negedge clk);
      end
      if8.out_ready = 1'b1;
      @(negedge clk);
      check("hold release out_valid", 32'(if8.out_valid), 32'd0);
      check("hold release in_ready", 32'(if8.in_ready), 32'd1);

      // Reset after bit 3 of 0xAA+0x55.
      if8.in_valid = 1'b1;
      if8.a        = 8'hAA;
      if8.b        = 8'h55;
      if8.cin      = 1'b0;
      @(negedge clk);
      if8.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("midrst busy before", 32'(if8.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst out_valid", 32'(if8.out_valid), 32'd0);
      check("midrst sum", 32'(if8.sum), 32'd0);
      check("midrst in_ready", 32'(if8.in_ready), 32'd1);
      check("midrst busy", 32'(if8.busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      start8(8'h01, 8'h01, 1'b0, 1'b1, "postrst");
      finish8(8'h02, 1'b0, "postrst");

      // New operands offered during SHIFT must be ignored.
      if8.in_valid = 1'b1;
      if8.a        = 8'h12;
      if8.b        = 8'h34;
      if8.cin      = 1'b0;
      @(negedge clk);
      cyc = 0;
      while (!if8.out_valid && cyc < 40) begin
         if8.in_valid = ~if8.in_valid;
         if8.a        = 8'($urandom);
         if8.b        = 8'($urandom);
         if8.cin      = ~if8.cin;
         @(negedge clk);
         cyc++;
      end
      if8.in_valid = 1'b0;
      check("overlap latency", 32'(cyc), 32'd8);
      finish8(8'h46, 1'b0, "overlap");

      // WIDTH=1 instance: 1+1+1 -> sum 1, carry 1, one edge in SHIFT.
      check("w1 in_ready", 32'(if1.in_ready), 32'd1);
      if1.in_valid = 1'b1;
      if1.a        = 1'b1;
      if1.b        = 1'b1;
      if1.cin      = 1'b1;
      @(negedge clk);
      if1.in_valid = 1'b0;
      check("w1 busy", 32'(if1.busy), 32'd1);
      @(negedge clk);
      check("w1 out_valid", 32'(if1.out_valid), 32'd1);
      check("w1 sum", 32'(if1.sum), 32'd1);
`ifdef SERIAL_ADDER_COUT_EN
      check("w1 cout", 32'(if1.cout), 32'd1);
`endif
      @(negedge clk);
      check("w1 in_ready after", 32'(if1.in_ready), 32'd1);
      check("w1 out_valid after", 32'(if1.out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
